// File: rtl/haze_pkg.sv
// Shared types for the pixel frame streamer: FSM state encoding, pixel type and RGB field positions.
package haze_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PASS1    = 3'd1,
        ST_WAIT_ALE = 3'd2,
        ST_GAP      = 3'd3,
        ST_PASS2    = 3'd4,
        ST_DONE     = 3'd5
    } stream_state_e;

    typedef logic [23:0] pixel_t;

    localparam int PIX_R_MSB = 32'd23;
    localparam int PIX_R_LSB = 32'd16;
    localparam int PIX_G_MSB = 32'd15;
    localparam int PIX_G_LSB = 32'd8;
    localparam int PIX_B_MSB = 32'd7;
    localparam int PIX_B_LSB = 32'd0;

    function automatic logic is_pass_state(input stream_state_e s);
        return (s == ST_PASS1) || (s == ST_PASS2);
    endfunction

endpackage

// File: rtl/pixel_addr_counter.sv
// Frame-buffer read address counter: clear to zero, increment, saturate at the last pixel.
module pixel_addr_counter #(
    parameter int COUNT_N = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              tc_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COUNT_N - 1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign tc_o   = (addr_q == LAST_ADDR);
    assign addr_o = addr_q;

    // Next address: clear wins, otherwise count up without wrapping past the last pixel.
    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (inc_i && !tc_o) begin
            addr_d = addr_q + ADDR_W'(1);
        end else begin
            addr_d = addr_q;
        end
    end

    // Address register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/pixel_frame_streamer.sv
// Two-pass frame-buffer reader feeding the haze core; PIXEL_STREAMER_STALL_EN adds an out_ready
// back-pressure input that throttles reads and holds the presented pixel.
module pixel_frame_streamer
    import haze_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int GAP_CYCLES = 2,
    localparam int N_PIX     = IMG_WIDTH * IMG_HEIGHT,
    localparam int ADDR_W    = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef PIXEL_STREAMER_STALL_EN
    input  logic              out_ready,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [23:0]       mem_data,
    input  logic              ale_done,
    output logic [23:0]       input_pixel,
    output logic              input_is_valid,
    output logic              enable,
    output logic              busy,
    output logic              frame_done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    stream_state_e      state_q;
    stream_state_e      state_d;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_d;
    logic               ready_s;
    logic               issue_s;
    logic               tc_s;
    logic               out_free_s;
    logic               fresh_q;
    logic               valid_q;
    pixel_t             hold_q;
    logic               enable_q;
    logic               busy_q;
    logic               frame_done_q;

`ifdef PIXEL_STREAMER_STALL_EN
    assign ready_s = out_ready;
`else
    assign ready_s = 1'b1;
`endif

    assign issue_s    = is_pass_state(state_q) && ready_s;
    // The presented pixel is gone after this cycle unless it is stalled.
    assign out_free_s = !valid_q || ready_s;

    pixel_addr_counter #(
        .COUNT_N (N_PIX),
        .ADDR_W  (ADDR_W)
    ) u_addr_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!is_pass_state(state_q)),
        .inc_i  (issue_s),
        .addr_o (mem_addr),
        .tc_o   (tc_s)
    );

    // Frame sequencing: two read passes separated by the ALE wait and a fixed gap.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_PASS1;
                else       state_d = ST_IDLE;
            end
            ST_PASS1: begin
                if (issue_s && tc_s) state_d = ST_WAIT_ALE;
                else                 state_d = ST_PASS1;
            end
            ST_WAIT_ALE: begin
                gap_d = '0;
                if (ale_done && out_free_s) state_d = (GAP_CYCLES == 0) ? ST_PASS2 : ST_GAP;
                else                        state_d = ST_WAIT_ALE;
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_PASS2;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_PASS2: begin
                if (issue_s && tc_s) state_d = ST_DONE;
                else                 state_d = ST_PASS2;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pixel-path and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gap_q        <= '0;
            fresh_q      <= 1'b0;
            valid_q      <= 1'b0;
            hold_q       <= '0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            fresh_q      <= issue_s;
            valid_q      <= issue_s || (valid_q && !ready_s);
            if (valid_q && !ready_s) begin
                hold_q <= input_pixel;
            end else begin
                hold_q <= hold_q;
            end
            enable_q     <= (state_d == ST_GAP) || (state_d == ST_PASS2) || (state_d == ST_DONE);
            busy_q       <= (state_d != ST_IDLE);
            frame_done_q <= (state_d == ST_DONE);
        end
    end

    // Read data arrives one cycle after the strobe; a stalled pixel is replayed from hold_q.
    assign input_pixel    = fresh_q ? mem_data : hold_q;
    assign input_is_valid = valid_q;
    assign mem_rd         = issue_s;
    assign enable         = enable_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Directed bench for pixel_frame_streamer (8x2 image, mem[i] = i) with an expected-pixel queue.
module tb_pixel_frame_streamer;

    localparam int W   = 8;
    localparam int H   = 2;
    localparam int GAP = 2;
    localparam int N   = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ale_done = 1'b0;
    logic        out_ready_tb = 1'b1;
    logic [3:0]  mem_addr;
    logic        mem_rd;
    logic [23:0] mem_data = 24'h0;
    logic [23:0] input_pixel;
    logic        input_is_valid;
    logic        enable;
    logic        busy;
    logic        frame_done;

    int          errors = 0;
    int          checks = 0;
    int          fd_count = 0;
    int          pix_count = 0;
    int          wait_n = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_v;
    logic        stall_mode = 1'b0;
    logic        prev_stalled = 1'b0;
    logic [23:0] prev_pix = 24'h0;

    always #5 clk = ~clk;

    // Frame buffer with mem[i] = i; unread cycles return junk so stale data is visible.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= {20'h0, mem_addr};
        else        mem_data <= 24'hFFFFFF;
    end

    pixel_frame_streamer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
`ifdef PIXEL_STREAMER_STALL_EN
        .out_ready      (out_ready_tb),
`endif
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .ale_done       (ale_done),
        .input_pixel    (input_pixel),
        .input_is_valid (input_is_valid),
        .enable         (enable),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) exp_q.push_back(24'(i));
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_addr"},  32'(mem_addr), 32'd0);
        check({pfx, "_rd"},    32'(mem_rd), 32'd0);
        check({pfx, "_pixel"}, 32'(input_pixel), 32'd0);
        check({pfx, "_valid"}, 32'(input_is_valid), 32'd0);
        check({pfx, "_enable"},32'(enable), 32'd0);
        check({pfx, "_busy"},  32'(busy), 32'd0);
        check({pfx, "_fdone"}, 32'(frame_done), 32'd0);
    endtask

    // One cycle: set ready for the coming edge, then score the presented pixel.
    task automatic cyc();
        @(negedge clk);
        if (stall_mode) out_ready_tb = ~out_ready_tb;
        if (prev_stalled) begin
            check("hold_valid", 32'(input_is_valid), 32'd1);
            check("hold_pixel", 32'(input_pixel), 32'(prev_pix));
        end
        if (input_is_valid && out_ready_tb) begin
            pix_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", 32'(input_pixel), 32'hFFFFFFFF);
            end else begin
                exp_v = exp_q.pop_front();
                check("pixel", 32'(input_pixel), 32'(exp_v));
            end
        end
        if (frame_done) begin
            fd_count++;
            check("frame_done_pixel", 32'(input_pixel), 32'h00000F);
            check("frame_done_valid", 32'(input_is_valid), 32'd1);
        end
        prev_stalled = input_is_valid && !out_ready_tb;
        prev_pix     = input_pixel;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        cyc();
        cyc();
        check("idle_busy", 32'(busy), 32'd0);

        // Pass 1: first valid two cycles after start, then contiguous.
        start = 1'b1;
        push_frame();
        cyc();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("rd_first", 32'(mem_rd), 32'd1);
        check("addr_first", 32'(mem_addr), 32'd0);
        check("valid_lat1", 32'(input_is_valid), 32'd0);
        cyc();
        check("first_valid_lat2", 32'(input_is_valid), 32'd1);
        for (int i = 1; i < N; i++) begin
            cyc();
            check("contiguous_p1", 32'(input_is_valid), 32'd1);
        end
        check("p1_drained", 32'(exp_q.size()), 32'd0);

        // ALE held low: nothing streams, enable stays low.
        for (int i = 0; i < 50; i++) begin
            cyc();
            check("wait_no_valid", 32'(input_is_valid), 32'd0);
            check("wait_enable_low", 32'(enable), 32'd0);
        end
        check("wait_busy", 32'(busy), 32'd1);

        ale_done = 1'b1;
        push_frame();
        cyc();
        check("enable_on_gap", 32'(enable), 32'd1);
        check("gap_no_valid", 32'(input_is_valid), 32'd0);
        wait_n = 0;
        while (!input_is_valid && wait_n < 20) begin
            cyc();
            wait_n++;
        end
        check("p2_first_latency", 32'(wait_n), 32'(GAP + 1));

        // Pass 2 with a stray start pulse that must be ignored.
        for (int i = 1; i < N; i++) begin
            if (i == 4) start = 1'b1;
            cyc();
            start = 1'b0;
            check("contiguous_p2", 32'(input_is_valid), 32'd1);
            if (i == N - 1) begin
                check("fd_on_last", 32'(frame_done), 32'd1);
                check("busy_at_done", 32'(busy), 32'd1);
                check("enable_at_done", 32'(enable), 32'd1);
            end
        end
        cyc();
        check("busy_clear", 32'(busy), 32'd0);
        check("enable_clear", 32'(enable), 32'd0);
        check("fd_single", 32'(frame_done), 32'd0);
        ale_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("idle_after_frame", 32'(busy), 32'd0);
        end
        check("frame_pixels", 32'(pix_count), 32'(2 * N));
        check("fd_count", 32'(fd_count), 32'd1);

        // Reset while pass-1 pixel 5 is presented.
        pix_count = 0;
        start = 1'b1;
        push_frame();
        cyc();
        start = 1'b0;
        wait_n = 0;
        while (pix_count < 6 && wait_n < 30) begin
            cyc();
            wait_n++;
        end
        check("reached_pix5", 32'(pix_count), 32'd6);
        rst = 1'b1;
        cyc();
        check_all_zero("rst_mid");
        rst = 1'b0;
        exp_q.delete();
        cyc();
        check("rst_stays_idle", 32'(busy), 32'd0);

        // Replay from address 0 with ale_done already high during pass 1.
        fd_count  = 0;
        pix_count = 0;
        ale_done  = 1'b1;
        start     = 1'b1;
        push_frame();
        push_frame();
        cyc();
        start = 1'b0;
        check("replay_addr0", 32'(mem_addr), 32'd0);
        check("replay_rd", 32'(mem_rd), 32'd1);
        wait_n = 0;
        while (exp_q.size() > 0 && wait_n < 100) begin
            cyc();
            wait_n++;
        end
        check("replay_drained", 32'(exp_q.size()), 32'd0);
        check("replay_pixels", 32'(pix_count), 32'(2 * N));
        check("replay_fd_count", 32'(fd_count), 32'd1);
        ale_done = 1'b0;
        repeat (3) cyc();

`ifdef PIXEL_STREAMER_STALL_EN
        // Toggled ready: every pixel transferred once, in order, stable while stalled.
        fd_count   = 0;
        pix_count  = 0;
        ale_done   = 1'b1;
        stall_mode = 1'b1;
        start      = 1'b1;
        push_frame();
        push_frame();
        cyc();
        start = 1'b0;
        wait_n = 0;
        while (exp_q.size() > 0 && wait_n < 400) begin
            cyc();
            wait_n++;
        end
        check("stall_drained", 32'(exp_q.size()), 32'd0);
        check("stall_pixels", 32'(pix_count), 32'(2 * N));
        repeat (3) cyc();
        check("stall_fd_count", 32'(fd_count), 32'd1);
        check("stall_idle", 32'(busy), 32'd0);
        stall_mode   = 1'b0;
        out_ready_tb = 1'b1;
        ale_done     = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
